// File: rtl/filter_ctrl.sv
// Kernel-select controller: debounced next/prev buttons pick one of four 3x3 kernels,
// which are streamed to the filter at frame start. Optional FILTER_CTRL_FRAME_CNT_EN adds frame_cnt.

module filter_ctrl_debounce #(
  parameter int CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic press_o
);
  localparam int CW = (CYC > 2) ? $clog2(CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;
  logic          press_q, press_d;

  // The accepted level flips only after CYC consecutive cycles disagreeing with it;
  // only the low->high flip emits a press.
  always_comb begin
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    press_d = 1'b0;
    if (d_i == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d   = '0;
      lvl_d   = d_i;
      press_d = d_i;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;
endmodule

module filter_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NUM_KERNELS     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bt_next,
  input  logic        bt_prev,
  input  logic        bypass_sw,
  input  logic        vs_i,
  input  logic        coef_ready,
  output logic        coef_we,
  output logic [3:0]  coef_addr,
  output logic [7:0]  coef_data,
  output logic [1:0]  active_kernel,
  output logic        cfg_apply,
  output logic        busy,
  output logic        bypass_o
`ifdef FILTER_CTRL_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, ARMED, LOAD, COMMIT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  sync1_q, sync2_q;
  logic [1:0]  press;
  logic        vs_q, vs_rise;
  logic [1:0]  pend_q, pend_d;
  logic [1:0]  active_q, active_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  tap_q, tap_d;
  logic        init_q, init_d;
  logic        byp_q;

  function automatic logic [7:0] coef_lut(input logic [1:0] k, input logic [3:0] t);
    logic [7:0] c;
    case (k)
      2'd0:    c = (t == 4'd4) ? 8'd16 : 8'd0;
      2'd1:    c = (t == 4'd4) ? 8'd4 : (t[0] ? 8'd2 : 8'd1);
      2'd2:    c = (t == 4'd4) ? 8'h50 : (t[0] ? 8'hF0 : 8'h00);
      default: c = (t == 4'd4) ? 8'hC0 : (t[0] ? 8'h10 : 8'h00);
    endcase
    return c;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      vs_q    <= 1'b0;
    end else begin
      sync1_q <= {bypass_sw, bt_prev, bt_next};
      sync2_q <= sync1_q;
      vs_q    <= vs_i;
    end
  end

  assign vs_rise = vs_i & ~vs_q;

  for (genvar g = 0; g < 2; g++) begin : g_db
    filter_ctrl_debounce #(.CYC(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .rst    (rst),
      .d_i    (sync2_q[g]),
      .press_o(press[g])
    );
  end

  // press[0] = next, press[1] = prev; simultaneous presses cancel.
  always_comb begin
    pend_d = pend_q;
    case (press)
      2'b01:   pend_d = pend_q + 2'd1;
      2'b10:   pend_d = pend_q - 2'd1;
      default: pend_d = pend_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tap_d     = tap_q;
    active_d  = active_q;
    init_d    = init_q;
    coef_we   = 1'b0;
    coef_addr = 4'd0;
    coef_data = 8'd0;
    cfg_apply = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_q != active_q || init_q) state_d = ARMED;
      end
      ARMED: begin
        busy = 1'b1;
        if (vs_rise) begin
          state_d = LOAD;
          idx_d   = pend_q;
          tap_d   = 4'd0;
        end
      end
      LOAD: begin
        busy      = 1'b1;
        coef_we   = 1'b1;
        coef_addr = tap_q;
        coef_data = coef_lut(idx_q, tap_q);
        if (coef_ready) begin
          if (tap_q == 4'd8) state_d = COMMIT;
          else               tap_d   = tap_q + 4'd1;
        end
      end
      default: begin
        busy      = 1'b1;
        cfg_apply = 1'b1;
        active_d  = idx_q;
        init_d    = 1'b0;
        tap_d     = 4'd0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pend_q   <= 2'd0;
      active_q <= 2'd0;
      idx_q    <= 2'd0;
      tap_q    <= 4'd0;
      init_q   <= 1'b1;
      byp_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      active_q <= active_d;
      idx_q    <= idx_d;
      tap_q    <= tap_d;
      init_q   <= init_d;
      if (vs_rise) byp_q <= sync2_q[2];
    end
  end

  assign active_kernel = active_q;
  assign bypass_o      = byp_q;

`ifdef FILTER_CTRL_FRAME_CNT_EN
  logic [15:0] frame_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          frame_q <= 16'd0;
    else if (vs_rise) frame_q <= frame_q + 16'd1;
  end
  assign frame_cnt = frame_q;
`endif
endmodule
